// File: rtl/pipe_ctrl_unit.sv
// Pipelined LEGv8 control unit: decodes the ID opcode and carries the control bundle through ID/EX, EX/MEM and MEM/WB.
// Define LOAD_USE_STALL_EN to build load-use hazard detection; without it stall is tied low.
module pipe_ctrl_unit #(
  parameter int OPC_W    = 11,
  parameter int REG_W    = 5,
  parameter int ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [OPC_W-1:0] instruction,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic [REG_W-1:0] id_rt,
  input  logic             flush,
  output logic             id_reg2loc,
  output logic             stall,
  output logic             ex_valid,
  output logic             ex_alusrc,
  output logic [1:0]       ex_aluop,
  output logic             ex_illegal,
  output logic [REG_W-1:0] ex_rd,
  output logic             mem_memread,
  output logic             mem_memwrite,
  output logic             mem_branch,
  output logic [REG_W-1:0] mem_rd,
  output logic             wb_regwrite,
  output logic             wb_memtoreg,
  output logic [REG_W-1:0] wb_rd
);

  localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

  typedef struct packed {
    logic             valid;
    logic             illegal;
    logic             alusrc;
    logic             memtoreg;
    logic             regwrite;
    logic             memread;
    logic             memwrite;
    logic             branch;
    logic [1:0]       aluop;
    logic [REG_W-1:0] rd;
  } ex_t;

  typedef struct packed {
    logic             memtoreg;
    logic             regwrite;
    logic             memread;
    logic             memwrite;
    logic             branch;
    logic [REG_W-1:0] rd;
  } mem_t;

  typedef struct packed {
    logic             memtoreg;
    logic             regwrite;
    logic [REG_W-1:0] rd;
  } wb_t;

  localparam ex_t EX_BUBBLE = '{valid: 1'b0, illegal: 1'b0, alusrc: 1'b0, memtoreg: 1'b0,
                                regwrite: 1'b0, memread: 1'b0, memwrite: 1'b0, branch: 1'b0,
                                aluop: 2'b00, rd: ZR};
  localparam mem_t MEM_BUBBLE = '{memtoreg: 1'b0, regwrite: 1'b0, memread: 1'b0,
                                  memwrite: 1'b0, branch: 1'b0, rd: ZR};
  localparam wb_t WB_BUBBLE = '{memtoreg: 1'b0, regwrite: 1'b0, rd: ZR};

  logic [10:0] opc;
  logic        is_r, is_ld, is_st, is_cbz, is_ill;
  ex_t         dec;
  ex_t         ex_d, ex_q;
  mem_t        mem_d, mem_q;
  wb_t         wb_d, wb_q;

  // Unknown opcodes decode to an all-zero bundle flagged illegal; an empty slot is never illegal.
  always_comb begin
    opc    = instruction[OPC_W-1 -: 11];
    is_r   = 1'b0;
    is_ld  = 1'b0;
    is_st  = 1'b0;
    is_cbz = 1'b0;
    is_ill = 1'b0;
    if (id_valid) begin
      casez (opc)
        11'b1??0101?000: is_r   = 1'b1;
        11'b11111000010: is_ld  = 1'b1;
        11'b11111000000: is_st  = 1'b1;
        11'b10110100???: is_cbz = 1'b1;
        default:         is_ill = 1'b1;
      endcase
    end
    dec.valid    = id_valid;
    dec.illegal  = is_ill;
    dec.alusrc   = is_ld | is_st;
    dec.memtoreg = is_ld;
    dec.regwrite = is_r | is_ld;
    dec.memread  = is_ld;
    dec.memwrite = is_st;
    dec.branch   = is_cbz;
    dec.aluop    = {is_r, is_cbz};
    dec.rd       = id_rt;
  end

  assign id_reg2loc = is_st | is_cbz;

`ifdef LOAD_USE_STALL_EN
  logic             uses_rn, uses_src2, hz;
  logic [REG_W-1:0] src2;

  // Only a load sitting in EX can hand its result too late for the instruction in ID.
  always_comb begin
    uses_rn   = is_r | is_ld | is_st;
    uses_src2 = is_r | is_st | is_cbz;
    src2      = id_reg2loc ? id_rt : id_rm;
    hz        = ex_q.valid & ex_q.memread & (ex_q.rd != ZR) & id_valid &
                ((uses_rn & (ex_q.rd == id_rn)) | (uses_src2 & (ex_q.rd == src2)));
  end

  assign stall = hz & ~flush;
`else
  logic unused_hz_inputs;
  assign unused_hz_inputs = ^{id_rn, id_rm};
  assign stall            = 1'b0;
`endif

  // A taken branch resolves in MEM: squash the two younger stages but let the branch retire.
  always_comb begin
    ex_d           = dec;
    mem_d.memtoreg = ex_q.memtoreg;
    mem_d.regwrite = ex_q.regwrite;
    mem_d.memread  = ex_q.memread;
    mem_d.memwrite = ex_q.memwrite;
    mem_d.branch   = ex_q.branch;
    mem_d.rd       = ex_q.rd;
    wb_d.memtoreg  = mem_q.memtoreg;
    wb_d.regwrite  = mem_q.regwrite;
    wb_d.rd        = mem_q.rd;
    if (flush) begin
      ex_d  = EX_BUBBLE;
      mem_d = MEM_BUBBLE;
    end else if (stall) begin
      ex_d = EX_BUBBLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= EX_BUBBLE;
      mem_q <= MEM_BUBBLE;
      wb_q  <= WB_BUBBLE;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_alusrc    = ex_q.alusrc;
  assign ex_aluop     = ex_q.aluop;
  assign ex_illegal   = ex_q.illegal;
  assign ex_rd        = ex_q.rd;
  assign mem_memread  = mem_q.memread;
  assign mem_memwrite = mem_q.memwrite;
  assign mem_branch   = mem_q.branch;
  assign mem_rd       = mem_q.rd;
  assign wb_regwrite  = wb_q.regwrite;
  assign wb_memtoreg  = wb_q.memtoreg;
  assign wb_rd        = wb_q.rd;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: decode vector table, hand-written pipeline corner cases and a random stream
// checked against an instruction-kind pipeline model.
module tb_pipe_ctrl_unit;

  localparam int ZR = 31;
`ifdef LOAD_USE_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100000;

  logic        clk, rst_n, id_valid, flush;
  logic [10:0] instruction;
  logic [4:0]  id_rn, id_rm, id_rt;
  logic        id_reg2loc, stall, ex_valid, ex_alusrc, ex_illegal;
  logic [1:0]  ex_aluop;
  logic [4:0]  ex_rd, mem_rd, wb_rd;
  logic        mem_memread, mem_memwrite, mem_branch, wb_regwrite, wb_memtoreg;

  pipe_ctrl_unit dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .instruction(instruction),
    .id_rn(id_rn), .id_rm(id_rm), .id_rt(id_rt), .flush(flush),
    .id_reg2loc(id_reg2loc), .stall(stall),
    .ex_valid(ex_valid), .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop),
    .ex_illegal(ex_illegal), .ex_rd(ex_rd),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .mem_branch(mem_branch),
    .mem_rd(mem_rd), .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_rd(wb_rd)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model: each stage holds an instruction kind and its destination
  typedef enum int {K_NONE, K_R, K_LD, K_ST, K_CBZ, K_ILL} kind_e;
  typedef struct {
    kind_e kind;
    int    rd;
  } slot_t;

  slot_t m_ex, m_mem, m_wb;
  int checks = 0;
  int errors = 0;

  function automatic kind_e classify(input logic v, input logic [10:0] op);
    int o;
    o = int'(op);
    if (!v) return K_NONE;
    if (o == 1986) return K_LD;
    if (o == 1984) return K_ST;
    if ((o >> 3) == 180) return K_CBZ;
    if ((o >> 10) == 1 && ((o >> 4) % 16) == 5 && (o % 8) == 0) return K_R;
    return K_ILL;
  endfunction

  function automatic bit model_hz(input kind_e k, input int rn, input int rm, input int rt);
    bit reads_rn, reads_src2;
    int src2;
    if (!STALL_EN || m_ex.kind != K_LD || m_ex.rd == ZR) return 1'b0;
    reads_rn   = (k == K_R) || (k == K_LD) || (k == K_ST);
    reads_src2 = (k == K_R) || (k == K_ST) || (k == K_CBZ);
    src2       = (k == K_R) ? rm : rt;
    return (reads_rn && rn == m_ex.rd) || (reads_src2 && src2 == m_ex.rd);
  endfunction

  function automatic bit model_stall();
    return model_hz(classify(id_valid, instruction), int'(id_rn), int'(id_rm), int'(id_rt)) && !flush;
  endfunction

  task automatic model_reset();
    m_ex  = '{K_NONE, ZR};
    m_mem = '{K_NONE, ZR};
    m_wb  = '{K_NONE, ZR};
  endtask

  task automatic model_step();
    bit st;
    st   = model_stall();
    m_wb = m_mem;
    if (flush) begin
      m_mem = '{K_NONE, ZR};
      m_ex  = '{K_NONE, ZR};
    end else if (st) begin
      m_mem = m_ex;
      m_ex  = '{K_NONE, ZR};
    end else begin
      m_mem = m_ex;
      m_ex  = '{classify(id_valid, instruction), int'(id_rt)};
    end
  endtask

  // scoreboard
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    kind_e idk;
    idk = classify(id_valid, instruction);
    chk("m_stall",    int'(stall),        int'(model_stall()));
    chk("m_reg2loc",  int'(id_reg2loc),   int'(idk == K_ST || idk == K_CBZ));
    chk("m_ex_valid", int'(ex_valid),     int'(m_ex.kind != K_NONE));
    chk("m_ex_alusrc",int'(ex_alusrc),    int'(m_ex.kind == K_LD || m_ex.kind == K_ST));
    chk("m_ex_aluop", int'(ex_aluop),     (m_ex.kind == K_R) ? 2 : (m_ex.kind == K_CBZ) ? 1 : 0);
    chk("m_ex_ill",   int'(ex_illegal),   int'(m_ex.kind == K_ILL));
    chk("m_ex_rd",    int'(ex_rd),        m_ex.rd);
    chk("m_mem_rd_en",int'(mem_memread),  int'(m_mem.kind == K_LD));
    chk("m_mem_wr",   int'(mem_memwrite), int'(m_mem.kind == K_ST));
    chk("m_mem_br",   int'(mem_branch),   int'(m_mem.kind == K_CBZ));
    chk("m_mem_rd",   int'(mem_rd),       m_mem.rd);
    chk("m_wb_rw",    int'(wb_regwrite),  int'(m_wb.kind == K_R || m_wb.kind == K_LD));
    chk("m_wb_m2r",   int'(wb_memtoreg),  int'(m_wb.kind == K_LD));
    chk("m_wb_rd",    int'(wb_rd),        m_wb.rd);
  endtask

  // drivers: called just after a rising edge
  task automatic set_in(input logic v, input logic [10:0] op, input int rn, input int rm,
                        input int rt, input logic fl);
    id_valid    = v;
    instruction = op;
    id_rn       = 5'(rn);
    id_rm       = 5'(rm);
    id_rt       = 5'(rt);
    flush       = fl;
  endtask

  task automatic tick();
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cycle(input logic v, input logic [10:0] op, input int rn, input int rm,
                       input int rt, input logic fl);
    set_in(v, op, rn, rm, rt, fl);
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 11'd0, 0, 0, ZR, 1'b0);
  endtask

  typedef struct {
    logic        v;
    logic [10:0] op;
    logic        r2l, alusrc;
    logic [1:0]  aluop;
    logic        ill, exv, mrd, mwr, br, rw, m2r;
  } vec_t;

  vec_t        vecs[12];
  logic [10:0] op_tab[7];

  initial begin
    int rt_v;
    vecs[0]  = '{1'b1, OP_ADD,         1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, OP_SUB,         1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, OP_AND,         1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, OP_ORR,         1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, OP_LDUR,        1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{1'b1, OP_STUR,        1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, OP_CBZ,         1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 11'b10110100101, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 11'b00000000000, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 11'b10001011001, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 11'b11111000011, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, OP_LDUR,        1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    op_tab   = '{OP_ADD, OP_SUB, OP_ORR, OP_LDUR, OP_STUR, OP_CBZ, 11'b10110100011};

    // power-on reset, checked before any clock edge
    rst_n = 1'b1;
    set_in(1'b0, 11'd0, 0, 0, ZR, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ex_valid", int'(ex_valid), 0);
    chk("rst_ex_rd",    int'(ex_rd), ZR);
    chk("rst_mem_rd",   int'(mem_rd), ZR);
    chk("rst_wb_rd",    int'(wb_rd), ZR);
    chk("rst_wb_rw",    int'(wb_regwrite), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    model_step();
    #1;

    // decode table walked through every stage
    for (int i = 0; i < 12; i++) begin
      rt_v = vecs[i].v ? 3 : ZR;
      set_in(vecs[i].v, vecs[i].op, 1, 2, rt_v, 1'b0);
      #1;
      chk("vec_reg2loc", int'(id_reg2loc), int'(vecs[i].r2l));
      chk("vec_stall",   int'(stall), 0);
      tick();
      chk("vec_ex_valid", int'(ex_valid),   int'(vecs[i].exv));
      chk("vec_ex_alusrc",int'(ex_alusrc),  int'(vecs[i].alusrc));
      chk("vec_ex_aluop", int'(ex_aluop),   int'(vecs[i].aluop));
      chk("vec_ex_ill",   int'(ex_illegal), int'(vecs[i].ill));
      chk("vec_ex_rd",    int'(ex_rd),      rt_v);
      cycle(1'b0, 11'd0, 0, 0, ZR, 1'b0);
      chk("vec_mem_rd_en",int'(mem_memread),  int'(vecs[i].mrd));
      chk("vec_mem_wr",   int'(mem_memwrite), int'(vecs[i].mwr));
      chk("vec_mem_br",   int'(mem_branch),   int'(vecs[i].br));
      chk("vec_mem_rd",   int'(mem_rd),       rt_v);
      cycle(1'b0, 11'd0, 0, 0, ZR, 1'b0);
      chk("vec_wb_rw",  int'(wb_regwrite), int'(vecs[i].rw));
      chk("vec_wb_m2r", int'(wb_memtoreg), int'(vecs[i].m2r));
      chk("vec_wb_rd",  int'(wb_rd),       rt_v);
      idle(1);
    end

    // load-use on Rn: one stall and one bubble, then the ADD enters EX
    cycle(1'b1, OP_LDUR, 1, 2, 5, 1'b0);
    set_in(1'b1, OP_ADD, 5, 6, 8, 1'b0);
    #1 chk("lu_stall", int'(stall), int'(STALL_EN));
    tick();
    chk("lu_bubble", int'(ex_valid), int'(!STALL_EN));
    #1 chk("lu_stall_clear", int'(stall), 0);
    tick();
    chk("lu_add_ex_valid", int'(ex_valid), 1);
    chk("lu_add_ex_aluop", int'(ex_aluop), 2);
    chk("lu_add_ex_rd",    int'(ex_rd), 8);
    idle(3);

    // XZR as load destination never stalls
    cycle(1'b1, OP_LDUR, 1, 2, ZR, 1'b0);
    set_in(1'b1, OP_ADD, ZR, ZR, 8, 1'b0);
    #1 chk("xzr_no_stall", int'(stall), 0);
    tick();
    idle(3);

    // CBZ reads only Rt
    cycle(1'b1, OP_LDUR, 1, 2, 7, 1'b0);
    set_in(1'b1, OP_CBZ, 7, 0, 7, 1'b0);
    #1 chk("cbz_rt_stall", int'(stall), int'(STALL_EN));
    tick();
    idle(3);
    cycle(1'b1, OP_LDUR, 1, 2, 7, 1'b0);
    set_in(1'b1, OP_CBZ, 7, 7, 2, 1'b0);
    #1 chk("cbz_rn_no_stall", int'(stall), 0);
    tick();
    idle(3);

    // STUR second source is Rt
    cycle(1'b1, OP_LDUR, 1, 2, 7, 1'b0);
    set_in(1'b1, OP_STUR, 1, 3, 7, 1'b0);
    #1 chk("stur_rt_stall", int'(stall), int'(STALL_EN));
    tick();
    idle(3);

    // flush wins over a simultaneous hazard; the MEM instruction retires
    cycle(1'b1, OP_ADD, 1, 2, 9, 1'b0);
    cycle(1'b1, OP_LDUR, 1, 2, 5, 1'b0);
    set_in(1'b1, OP_ADD, 5, 6, 8, 1'b1);
    #1 chk("flush_stall", int'(stall), 0);
    tick();
    chk("flush_ex_valid",  int'(ex_valid), 0);
    chk("flush_mem_rd_en", int'(mem_memread), 0);
    chk("flush_mem_rd",    int'(mem_rd), ZR);
    chk("flush_wb_rw",     int'(wb_regwrite), 1);
    chk("flush_wb_rd",     int'(wb_rd), 9);
    idle(3);

    // branch in MEM retires while the younger STUR is squashed
    cycle(1'b1, OP_CBZ, 0, 0, 4, 1'b0);
    cycle(1'b1, OP_STUR, 1, 2, 6, 1'b0);
    cycle(1'b1, OP_ADD, 1, 2, 3, 1'b1);
    chk("flush2_mem_wr", int'(mem_memwrite), 0);
    chk("flush2_mem_br", int'(mem_branch), 0);
    chk("flush2_ex_valid", int'(ex_valid), 0);
    idle(3);

    // random stream against the model
    for (int n = 0; n < 500; n++) begin
      logic        v, fl;
      logic [10:0] op;
      int          sel, rn, rm, rt;
      v   = ($urandom_range(0, 9) != 0);
      sel = $urandom_range(0, 7);
      op  = (sel == 7) ? 11'($urandom_range(0, 2047)) : op_tab[sel];
      rn  = $urandom_range(0, 4); if (rn == 4) rn = ZR;
      rm  = $urandom_range(0, 4); if (rm == 4) rm = ZR;
      rt  = $urandom_range(0, 4); if (rt == 4) rt = ZR;
      if (!v) rt = ZR;
      fl  = ($urandom_range(0, 9) == 0);
      cycle(v, op, rn, rm, rt, fl);
    end
    idle(3);

    // asynchronous reset mid-stream, then a clean restart
    cycle(1'b1, OP_ADD, 1, 2, 9, 1'b0);
    cycle(1'b1, OP_LDUR, 1, 2, 10, 1'b0);
    cycle(1'b1, OP_ADD, 1, 2, 11, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_ex_valid", int'(ex_valid), 0);
    chk("mrst_ex_aluop", int'(ex_aluop), 0);
    chk("mrst_ex_rd",    int'(ex_rd), ZR);
    chk("mrst_mem_rd_en",int'(mem_memread), 0);
    chk("mrst_mem_rd",   int'(mem_rd), ZR);
    chk("mrst_wb_rw",    int'(wb_regwrite), 0);
    chk("mrst_wb_rd",    int'(wb_rd), ZR);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    set_in(1'b1, OP_ADD, 1, 2, 4, 1'b0);
    @(posedge clk);
    model_step();
    #1;
    chk("rel_ex_valid", int'(ex_valid), 1);
    chk("rel_ex_rd",    int'(ex_rd), 4);
    chk("rel_mem_rd",   int'(mem_rd), ZR);
    chk("rel_wb_rd",    int'(wb_rd), ZR);
    chk("rel_wb_rw",    int'(wb_regwrite), 0);
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Pipelined successor to the single-cycle LEGv8 main decoder.
- Decodes the 11-bit opcode in ID and carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards and stalls. Applies branch flush bubbles.
- Unknown opcodes decode to a safe all-zero bundle with an illegal flag; the old decoder held stale values instead.

Parameters:
- OPC_W, 11, opcode field width; decode uses bits [OPC_W-1 -: 11], so OPC_W must be ≥ 11.
- REG_W, 5, register address width.
- ZERO_REG, 31, index of XZR; never creates a hazard.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  IF/ID holds a real instruction.
- instruction  in  OPC_W  opcode field of the ID instruction.
- id_rn  in  REG_W  Rn field.
- id_rm  in  REG_W  Rm field.
- id_rt  in  REG_W  Rd/Rt field.
- flush  in  1  branch taken, resolved in MEM.
- id_reg2loc  out  1  combinational; register-file read-port-2 select.
- stall  out  1  combinational; hold PC and IF/ID.
- ex_valid, ex_alusrc  out  1 each  EX stage controls.
- ex_aluop  out  2  EX stage ALU operation.
- ex_illegal  out  1  EX stage illegal-opcode flag.
- ex_rd  out  REG_W  EX stage destination register.
- mem_memread, mem_memwrite, mem_branch  out  1 each  MEM stage controls.
- mem_rd  out  REG_W  MEM stage destination register.
- wb_regwrite, wb_memtoreg  out  1 each  WB stage controls.
- wb_rd  out  REG_W  WB stage destination register.

Behaviour:
- Decode (combinational, ID). Bundle fields are {reg2loc, alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop}.
  - R-type 1xx0101x000 -> 0,0,0,1,0,0,0,10
  - LDUR 11111000010 -> 0,1,1,1,1,0,0,00
  - STUR 11111000000 -> 1,1,0,0,0,1,0,00
  - CBZ 10110100xxx -> 1,0,0,0,0,0,1,01
  - Any other opcode -> all zero, with illegal=1.
  - If id_valid=0, the bundle is all zero and illegal=0.
- Source usage:
  - uses_rn = R|LDUR|STUR.
  - uses_src2 = R|STUR|CBZ.
  - src2 = reg2loc ? id_rt : id_rm.
- Load-use detect: hz = ex_valid & ex_memread_int & (ex_rd != ZERO_REG) & id_valid & ((uses_rn & ex_rd==id_rn) | (uses_src2 & ex_rd==src2)). Then stall = hz & ~flush.
- Register update each rising edge, in priority order:
  - flush=1: ID/EX <= bubble and EX/MEM <= bubble. MEM/WB <= EX/MEM, so the branch itself retires.
  - else stall=1: ID/EX <= bubble; EX/MEM <= ID/EX; MEM/WB <= EX/MEM.
  - else: normal shift; ID/EX <= decoded bundle with rd = id_rt.
- Bubble definition: all control bits 0, valid=0, illegal=0, rd=ZERO_REG.
- Latency: an instruction decoded in ID in cycle n drives ex_* in n+1, mem_* in n+2 and wb_* in n+3.
- Writeback uses the registered wb_rd only; it is never combinational from the ID fields.
- Reset (rst_n=0, asynchronous): all stage registers take the bubble value, so every registered output is 0 and every *_rd output equals ZERO_REG. stall and id_reg2loc follow the current inputs.
- Reset deasserted mid-stream: the first edge after release loads only the ID decode; there are no stale stages.
- ex_illegal propagates with its bundle. Illegal instructions never assert regwrite, memwrite or branch.

Optional Feature:
- Macro LOAD_USE_STALL_EN.
- Defined: hazard detection exactly as in Behaviour.
- Undefined: stall is tied to 0, no detection logic is built, and ID/EX always loads the decode (or a bubble on flush). Software scheduling then covers load-use hazards.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> all ex_/mem_/wb_ control outputs are 0 and all *_rd = 31, immediately and without waiting for clk.
- Pipeline timing: issue ADD (11'b10001011000, rt=3) then idle -> ex_aluop=10 at n+1; wb_regwrite=1, wb_memtoreg=0, wb_rd=3 at n+3.
- Load-use: LDUR rt=5, then ADD rn=5 -> stall=1 for one cycle and one bubble in EX. ADD reaches EX one cycle later. A dependence on rt=31 gives no stall.
- CBZ / STUR source select: LDUR rt=7, then CBZ rt=7 with rn=7 -> stall. LDUR rt=7, then CBZ rt=2 with rn=7 -> no stall (CBZ does not use Rn).
- Flush with a simultaneous hazard: flush=1 while hz=1 -> stall=0. ex_valid and mem_memwrite/mem_branch are 0 the next cycle, and the instruction that was in MEM reaches WB.
- Illegal opcode 11'b00000000000 with id_valid=1 -> ex_illegal=1 and every control bit 0. With the macro undefined, repeat the load-use case -> stall stays 0.
